pwm_period_sequencer: RTL
=========================

Name: pwm_period_sequencer

Overview:
- Multi-channel PWM/tone engine driven by the CPU-side period and decode register exports.
- Each channel runs a free counter over `period` cycles. Its output is high while the count is below `decode`.
- A request/acknowledge handshake moves a new period/decode set into all channels. Each channel takes the new values only at its own period boundary, so no channel ever produces a runt or glitched cycle.

Parameters:
- NCH, 8, number of channels.
- W, 28, width of period/decode values and counters.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous active-high reset.
- period_in  in  NCH*W  requested periods; channel i at [i*W +: W].
- decode_in  in  NCH*W  requested high-times (duty); same packing.
- enable  in  NCH  per-channel run enable.
- update_req  in  1  level request to load period_in/decode_in.
- update_ack  out  1  all channels have applied the captured set.
- busy  out  1  a captured set is still pending in at least one channel.
- pwm_out  out  NCH  registered PWM outputs.
- wrap_pulse  out  NCH  one-cycle strobe in the cycle a channel's count is 0 after a wrap or load.

Behaviour:
- Reset (async, immediate):
  - All counters, active P/D registers, shadow registers and pending bits are cleared to 0.
  - Controller goes to IDLE.
  - pwm_out=0, wrap_pulse=0, update_ack=0, busy=0.
- Per channel (active P, D, counter cnt):
  - While enabled and P>=1: cnt counts 0..P-1 and then wraps to 0.
  - pwm_out[i] is a flop updated together with cnt, so in every cycle pwm_out[i] == (enable_r && P>=1 && cnt<D).
  - D=0 gives constant low. D>=P gives constant high.
  - wrap_pulse[i] is 1 in each cycle where cnt==0 because of a wrap or a load. It is never 1 while the channel is disabled.
  - P=0: channel idle. cnt held at 0, pwm_out=0, no wrap_pulse.
  - Enable falling: next cycle cnt=0, pwm_out=0. Any pending set for the channel is applied in that cycle.
  - Enable rising (sampled at edge t): cycle t+1 has cnt=0, wrap_pulse=1, and pwm_out=(D>0).
- Controller FSM, states IDLE, PENDING, ACK:
  - IDLE -> PENDING: when update_req=1.
    - In that same edge, period_in/decode_in are captured into the shadow registers for all channels.
    - Pending bits are set for all channels.
    - busy=1 from the next cycle.
  - PENDING, per channel:
    - Enabled channel with P>=1: applies its shadow P/D at the edge where cnt==P-1. The next cycle has cnt=0 under the new values, and its pending bit clears.
    - Disabled or P=0 channel: applies at the next edge.
    - A wrap and an apply in the same cycle count as one event.
  - PENDING -> ACK: when all pending bits are 0. busy=0, update_ack=1.
  - ACK -> IDLE: when update_req=0. update_ack drops in the cycle after update_req is sampled low.
  - Requests while in PENDING or ACK are ignored; there is no recapture. Changes to period_in/decode_in after capture have no effect.
- Latency:
  - Minimum request-to-ack time is 2 cycles (all channels disabled).
  - Maximum request-to-ack time is max(P_old)+1 cycles.
- Arithmetic:
  - Unsigned W-bit values.
  - The wrap comparison is cnt==P-1, computed for P>=1 only; no underflow.

Decomposition:
- Shared package: FSM state enum (IDLE/PENDING/ACK) and default widths NCH=8, W=28.
- One sub-module, pwm_channel, instantiated NCH times:
  - Inputs: enable, shadow P/D, apply_req.
  - Outputs: pwm, wrap, applied.
- The top level holds the shadow registers, the pending vector and the FSM.

Test Plan:
1. Reset mid-run (ch0 P=10, D=3, enabled, reset at cycle 57) -> all outputs 0 in the reset cycle; after release, ch0 idle with P=0.
2. Load ch0 P=10, D=3 with enable=1 -> pwm_out[0] shows 3 high, 7 low, repeating; wrap_pulse[0] every 10 cycles; update_ack rises 2 cycles after the request while ch0 is disabled during the load.
3. ch0 running P=10, D=3 at cnt=4; request P=4, D=2 -> no change for 5 cycles, then 2 high, 2 low; busy is 1 for exactly 6 cycles; update_ack follows; no runt pulse.
4. Boundary duty: D=0 gives constant 0. D=P=5 and D=9, P=5 give constant 1. P=1, D=1 gives constant 1 with wrap_pulse every cycle.
5. Second update_req edge while PENDING with different data -> ignored; applied values equal the first capture; update_ack held until update_req falls.
6. All 8 channels at periods 3..10 with one update -> each channel switches exactly at its own wrap; ack arrives 11 cycles worst case; enable of ch5 dropped mid-pending -> ch5 applies next cycle and pwm_out[5]=0.

Source files
------------

// File: rtl/pwm_period_sequencer_pkg.sv
// rtl/pwm_period_sequencer_pkg.sv - shared types and default sizes for the PWM period sequencer
package pwm_period_sequencer_pkg;

    localparam int NCH_DEF = 8;
    localparam int W_DEF   = 28;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACK     = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pwm_period_sequencer_if.sv
// rtl/pwm_period_sequencer_if.sv - register export, update handshake and PWM output bundle
interface pwm_period_sequencer_if
    import pwm_period_sequencer_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
);
    logic [NCH*W-1:0] period_in;
    logic [NCH*W-1:0] decode_in;
    logic [NCH-1:0]   enable;
    logic             update_req;
    logic             update_ack;
    logic             busy;
    logic [NCH-1:0]   pwm_out;
    logic [NCH-1:0]   wrap_pulse;

    modport master (
        output period_in, decode_in, enable, update_req,
        input  update_ack, busy, pwm_out, wrap_pulse
    );

    modport slave (
        input  period_in, decode_in, enable, update_req,
        output update_ack, busy, pwm_out, wrap_pulse
    );
endinterface

// File: rtl/pwm_period_sequencer_channel.sv
// rtl/pwm_period_sequencer_channel.sv - one PWM channel that swaps period/duty only at its own boundary
module pwm_channel
    import pwm_period_sequencer_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         apply_req,
    input  logic [W-1:0] shadow_p,
    input  logic [W-1:0] shadow_d,
    output logic         pwm,
    output logic         wrap,
    output logic         applied
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] p, d, cnt;
    logic         en_r;
    logic [W-1:0] p_n, d_n, cnt_n;
    logic         running, at_end, restart;

    // A running channel only swaps at cnt==P-1; an idle or disabled one swaps at once.
    always_comb begin
        running = en_r && (p != '0);
        at_end  = running && (cnt == p - ONE);
        applied = apply_req && (!enable || !running || at_end);
        p_n     = applied ? shadow_p : p;
        d_n     = applied ? shadow_d : d;
        restart = applied || !en_r || at_end;
        if (!enable || (p_n == '0) || restart) begin
            cnt_n = '0;
        end else begin
            cnt_n = cnt + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p    <= '0;
            d    <= '0;
            cnt  <= '0;
            en_r <= 1'b0;
            pwm  <= 1'b0;
            wrap <= 1'b0;
        end else begin
            p    <= p_n;
            d    <= d_n;
            cnt  <= cnt_n;
            en_r <= enable;
            pwm  <= enable && (p_n != '0) && (cnt_n < d_n);
            wrap <= enable && (p_n != '0) && restart;
        end
    end

endmodule

// File: rtl/pwm_period_sequencer.sv
// rtl/pwm_period_sequencer.sv - multi-channel PWM engine with glitch-free handshaked period/duty updates
module pwm_period_sequencer
    import pwm_period_sequencer_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    pwm_period_sequencer_if.slave   bus
);
    seq_state_t       state, state_n;
    logic             capture;
    logic [NCH*W-1:0] shadow_p, shadow_d;
    logic [NCH-1:0]   pending, applied;
    logic [NCH-1:0]   pwm_v, wrap_v;

    always_comb begin
        state_n = state;
        capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.update_req) begin
                    state_n = ST_PENDING;
                    capture = 1'b1;
                end
            end
            ST_PENDING: begin
                if (pending == '0) begin
                    state_n = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!bus.update_req) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Shadow copies are taken only on the IDLE->PENDING edge, so later input changes are inert.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state    <= ST_IDLE;
            shadow_p <= '0;
            shadow_d <= '0;
            pending  <= '0;
        end else begin
            state <= state_n;
            if (capture) begin
                shadow_p <= bus.period_in;
                shadow_d <= bus.decode_in;
                pending  <= '1;
            end else begin
                pending  <= pending & ~applied;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_channel #(.W(W)) u_ch (
            .clk       (clk_clk),
            .rst       (reset_reset),
            .enable    (bus.enable[i]),
            .apply_req (pending[i]),
            .shadow_p  (shadow_p[i*W +: W]),
            .shadow_d  (shadow_d[i*W +: W]),
            .pwm       (pwm_v[i]),
            .wrap      (wrap_v[i]),
            .applied   (applied[i])
        );
    end

    assign bus.pwm_out    = pwm_v;
    assign bus.wrap_pulse = wrap_v;
    assign bus.busy       = (state == ST_PENDING);
    assign bus.update_ack = (state == ST_ACK);

endmodule
